// File: rtl/reg_arb_pkg.sv
// Shared types and default widths for the register-file write arbiter.
package reg_arb_pkg;

    localparam int unsigned REG_W = 8;
    localparam int unsigned REG_D = 3;

    typedef enum logic {
        ARB   = 1'b0,
        CLEAR = 1'b1
    } arb_state_t;

endpackage

// File: rtl/reg_wr_slot.sv
// One-entry hold buffer for a single write requester.
module reg_wr_slot
    import reg_arb_pkg::*;
#(
    parameter int unsigned W = REG_W,
    parameter int unsigned D = REG_D
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [D-1:0] ld_addr,
    input  logic [W-1:0] ld_data,
    input  logic         drain,
    output logic         valid,
    output logic [D-1:0] addr,
    output logic [W-1:0] data
);

    logic         hv_q, hv_d;
    logic [D-1:0] ha_q, ha_d;
    logic [W-1:0] hd_q, hd_d;

    // A load in the same cycle as a drain refills the slot.
    always_comb begin
        hv_d = hv_q;
        ha_d = ha_q;
        hd_d = hd_q;
        if (load) begin
            hv_d = 1'b1;
            ha_d = ld_addr;
            hd_d = ld_data;
        end else if (drain) begin
            hv_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hv_q <= 1'b0;
            ha_q <= '0;
            hd_q <= '0;
        end else begin
            hv_q <= hv_d;
            ha_q <= ha_d;
            hd_q <= hd_d;
        end
    end

    assign valid = hv_q;
    assign addr  = ha_q;
    assign data  = hd_q;

endmodule

// File: rtl/reg_wr_arbiter.sv
// Round-robin owner of the reg_file write port, with a one-write-per-cycle clear sweep.
module reg_wr_arbiter
    import reg_arb_pkg::*;
#(
    parameter int unsigned W = REG_W,
    parameter int unsigned D = REG_D
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         req0_valid,
    output logic         req0_ready,
    input  logic [D-1:0] req0_addr,
    input  logic [W-1:0] req0_data,
    input  logic         req1_valid,
    output logic         req1_ready,
    input  logic [D-1:0] req1_addr,
    input  logic [W-1:0] req1_data,
    input  logic         clr_req,
    output logic         clr_busy,
    output logic         clr_done,
    output logic         wr_en,
    output logic [D-1:0] wr_addr,
    output logic [W-1:0] wr_data,
    output logic [1:0]   grant
);

    localparam logic [D-1:0] LAST_ADDR = '1;

    arb_state_t   state_q, state_d;
    logic [D-1:0] clr_ptr_q, clr_ptr_d;
    logic         rr_last_q, rr_last_d;
    logic         run_q;

    logic         hv0, hv1;
    logic [D-1:0] ha0, ha1;
    logic [W-1:0] hd0, hd1;
    logic         acc0, acc1;

    // run_q keeps the readys low while reset is asserted and for the first edge after.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ARB;
            clr_ptr_q <= '0;
            rr_last_q <= 1'b1;
            run_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            clr_ptr_q <= clr_ptr_d;
            rr_last_q <= rr_last_d;
            run_q     <= 1'b1;
        end
    end

    always_comb begin
        state_d   = state_q;
        clr_ptr_d = clr_ptr_q;
        rr_last_d = rr_last_q;
        grant     = 2'b00;
        wr_en     = 1'b0;
        wr_addr   = '0;
        wr_data   = '0;
        clr_busy  = 1'b0;
        clr_done  = 1'b0;
        case (state_q)
            ARB: begin
                // Tie goes to the port that did not win last time.
                if (hv0 && hv1) begin
                    grant = rr_last_q ? 2'b01 : 2'b10;
                end else if (hv0) begin
                    grant = 2'b01;
                end else if (hv1) begin
                    grant = 2'b10;
                end
                if (grant[0]) begin
                    wr_en   = 1'b1;
                    wr_addr = ha0;
                    wr_data = hd0;
                end else if (grant[1]) begin
                    wr_en   = 1'b1;
                    wr_addr = ha1;
                    wr_data = hd1;
                end
                if (grant != 2'b00) begin
                    rr_last_d = grant[1];
                end
                if (clr_req) begin
                    state_d   = CLEAR;
                    clr_ptr_d = '0;
                end
            end
            CLEAR: begin
                wr_en     = 1'b1;
                wr_addr   = clr_ptr_q;
                clr_busy  = 1'b1;
                clr_ptr_d = clr_ptr_q + D'(1);
                if (clr_ptr_q == LAST_ADDR) begin
                    clr_done = 1'b1;
                    state_d  = ARB;
                end
            end
            default: state_d = ARB;
        endcase
    end

    // Readys depend only on state, never on the valids.
    always_comb begin
        req0_ready = run_q && (state_q == ARB) && (!hv0 || grant[0]);
        req1_ready = run_q && (state_q == ARB) && (!hv1 || grant[1]);
        acc0       = req0_valid && req0_ready;
        acc1       = req1_valid && req1_ready;
    end

    reg_wr_slot #(.W(W), .D(D)) u_slot0 (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (acc0),
        .ld_addr (req0_addr),
        .ld_data (req0_data),
        .drain   (grant[0]),
        .valid   (hv0),
        .addr    (ha0),
        .data    (hd0)
    );

    reg_wr_slot #(.W(W), .D(D)) u_slot1 (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (acc1),
        .ld_addr (req1_addr),
        .ld_data (req1_data),
        .drain   (grant[1]),
        .valid   (hv1),
        .addr    (ha1),
        .data    (hd1)
    );

endmodule

// File: tb/tb_reg_wr_arbiter.sv
// Directed bench for reg_wr_arbiter: vector table plus hand-written clear/reset sequences.
module tb_reg_wr_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req0_valid, req1_valid, clr_req;
    logic [2:0] req0_addr, req1_addr;
    logic [7:0] req0_data, req1_data;
    logic       req0_ready, req1_ready, clr_busy, clr_done, wr_en;
    logic [2:0] wr_addr;
    logic [7:0] wr_data;
    logic [1:0] grant;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    reg_wr_arbiter dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_addr  (req0_addr),
        .req0_data  (req0_data),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_addr  (req1_addr),
        .req1_data  (req1_data),
        .clr_req    (clr_req),
        .clr_busy   (clr_busy),
        .clr_done   (clr_done),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .grant      (grant)
    );

    typedef struct {
        logic       v0;
        logic [2:0] a0;
        logic [7:0] d0;
        logic       v1;
        logic [2:0] a1;
        logic [7:0] d1;
        logic       clr;
        logic       e_we;
        logic [2:0] e_a;
        logic [7:0] e_d;
        logic [1:0] e_g;
        logic       e_r0;
        logic       e_r1;
    } vec_t;

    function automatic vec_t mk(logic v0, logic [2:0] a0, logic [7:0] d0,
                                logic v1, logic [2:0] a1, logic [7:0] d1,
                                logic we, logic [2:0] ea, logic [7:0] ed,
                                logic [1:0] eg, logic r0, logic r1);
        vec_t v;
        v.v0 = v0; v.a0 = a0; v.d0 = d0;
        v.v1 = v1; v.a1 = a1; v.d1 = d1;
        v.clr = 1'b0;
        v.e_we = we; v.e_a = ea; v.e_d = ed; v.e_g = eg;
        v.e_r0 = r0; v.e_r1 = r1;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive_idle();
        req0_valid = 1'b0; req0_addr = '0; req0_data = '0;
        req1_valid = 1'b0; req1_addr = '0; req1_data = '0;
        clr_req    = 1'b0;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, ".wr_en"}, 32'(wr_en), 0);
        chk({tag, ".wr_addr"}, 32'(wr_addr), 0);
        chk({tag, ".wr_data"}, 32'(wr_data), 0);
        chk({tag, ".grant"}, 32'(grant), 0);
        chk({tag, ".ready0"}, 32'(req0_ready), 0);
        chk({tag, ".ready1"}, 32'(req1_ready), 0);
        chk({tag, ".busy"}, 32'(clr_busy), 0);
        chk({tag, ".done"}, 32'(clr_done), 0);
    endtask

    task automatic check_idle(input string tag);
        chk({tag, ".wr_en"}, 32'(wr_en), 0);
        chk({tag, ".grant"}, 32'(grant), 0);
        chk({tag, ".ready0"}, 32'(req0_ready), 1);
        chk({tag, ".ready1"}, 32'(req1_ready), 1);
        chk({tag, ".busy"}, 32'(clr_busy), 0);
        chk({tag, ".done"}, 32'(clr_done), 0);
    endtask

    task automatic check_write(input string tag, input logic [2:0] a, input logic [7:0] d,
                               input logic [1:0] g);
        chk({tag, ".wr_en"}, 32'(wr_en), 1);
        chk({tag, ".wr_addr"}, 32'(wr_addr), 32'(a));
        chk({tag, ".wr_data"}, 32'(wr_data), 32'(d));
        chk({tag, ".grant"}, 32'(grant), 32'(g));
        chk({tag, ".busy"}, 32'(clr_busy), 0);
    endtask

    // Called at a negedge in the clear cycle whose pointer should be idx.
    task automatic check_clear(input string tag, input int idx);
        chk({tag, ".wr_en"}, 32'(wr_en), 1);
        chk({tag, ".wr_addr"}, 32'(wr_addr), 32'(idx));
        chk({tag, ".wr_data"}, 32'(wr_data), 0);
        chk({tag, ".grant"}, 32'(grant), 0);
        chk({tag, ".ready0"}, 32'(req0_ready), 0);
        chk({tag, ".ready1"}, 32'(req1_ready), 0);
        chk({tag, ".busy"}, 32'(clr_busy), 1);
        chk({tag, ".done"}, 32'(clr_done), (idx == 7) ? 1 : 0);
    endtask

    task automatic clear_sweep(input string tag);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check_clear(tag, i);
            clr_req = 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vt [8];
        logic       m_hv [2];
        logic [2:0] m_ha [2];
        logic [7:0] m_hd [2];
        logic       rr;
        int         k0, k1, w0, w1;
        logic [1:0] eg;
        logic       er0, er1;

        // Reset with random inputs: every output low.
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            req0_valid = 1'($urandom); req0_addr = 3'($urandom); req0_data = 8'($urandom);
            req1_valid = 1'($urandom); req1_addr = 3'($urandom); req1_data = 8'($urandom);
            clr_req    = 1'($urandom);
            @(negedge clk);
            check_zero("rst");
        end
        drive_idle();
        rst_n = 1'b1;
        @(posedge clk);

        // Single writes, port-1 alone, tie-break and back-pressure.
        vt[0] = mk(1, 3'd3, 8'hA5, 0, 3'd0, 8'h00, 0, 3'd0, 8'h00, 2'b00, 1, 1);
        vt[1] = mk(0, 3'd0, 8'h00, 0, 3'd0, 8'h00, 1, 3'd3, 8'hA5, 2'b01, 1, 1);
        vt[2] = mk(0, 3'd0, 8'h00, 1, 3'd6, 8'h11, 0, 3'd0, 8'h00, 2'b00, 1, 1);
        vt[3] = mk(1, 3'd1, 8'h21, 1, 3'd2, 8'h22, 1, 3'd6, 8'h11, 2'b10, 1, 1);
        vt[4] = mk(0, 3'd0, 8'h00, 1, 3'd7, 8'h77, 1, 3'd1, 8'h21, 2'b01, 1, 0);
        vt[5] = mk(0, 3'd0, 8'h00, 1, 3'd7, 8'h77, 1, 3'd2, 8'h22, 2'b10, 1, 1);
        vt[6] = mk(0, 3'd0, 8'h00, 0, 3'd0, 8'h00, 1, 3'd7, 8'h77, 2'b10, 1, 1);
        vt[7] = mk(0, 3'd0, 8'h00, 0, 3'd0, 8'h00, 0, 3'd0, 8'h00, 2'b00, 1, 1);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk($sformatf("vec%0d.wr_en", i), 32'(wr_en), 32'(vt[i].e_we));
            chk($sformatf("vec%0d.wr_addr", i), 32'(wr_addr), 32'(vt[i].e_a));
            chk($sformatf("vec%0d.wr_data", i), 32'(wr_data), 32'(vt[i].e_d));
            chk($sformatf("vec%0d.grant", i), 32'(grant), 32'(vt[i].e_g));
            chk($sformatf("vec%0d.ready0", i), 32'(req0_ready), 32'(vt[i].e_r0));
            chk($sformatf("vec%0d.ready1", i), 32'(req1_ready), 32'(vt[i].e_r1));
            chk($sformatf("vec%0d.busy", i), 32'(clr_busy), 0);
            req0_valid = vt[i].v0; req0_addr = vt[i].a0; req0_data = vt[i].d0;
            req1_valid = vt[i].v1; req1_addr = vt[i].a1; req1_data = vt[i].d1;
            clr_req    = vt[i].clr;
        end

        // Both ports streaming: alternate grants, nothing lost or duplicated.
        m_hv[0] = 1'b0; m_hv[1] = 1'b0;
        m_ha[0] = '0; m_ha[1] = '0; m_hd[0] = '0; m_hd[1] = '0;
        rr = 1'b1;
        k0 = 0; k1 = 0; w0 = 0; w1 = 0;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            eg = 2'b00;
            if (m_hv[0] && m_hv[1]) eg = rr ? 2'b01 : 2'b10;
            else if (m_hv[0])       eg = 2'b01;
            else if (m_hv[1])       eg = 2'b10;
            chk($sformatf("rr%0d.grant", c), 32'(grant), 32'(eg));
            chk($sformatf("rr%0d.wr_en", c), 32'(wr_en), (eg != 2'b00) ? 1 : 0);
            if (eg[0]) begin
                chk($sformatf("rr%0d.addr", c), 32'(wr_addr), 32'(m_ha[0]));
                chk($sformatf("rr%0d.data", c), 32'(wr_data), 32'(m_hd[0]));
                m_hv[0] = 1'b0; rr = 1'b0; w0++;
            end else if (eg[1]) begin
                chk($sformatf("rr%0d.addr", c), 32'(wr_addr), 32'(m_ha[1]));
                chk($sformatf("rr%0d.data", c), 32'(wr_data), 32'(m_hd[1]));
                m_hv[1] = 1'b0; rr = 1'b1; w1++;
            end
            er0 = !m_hv[0];
            er1 = !m_hv[1];
            chk($sformatf("rr%0d.ready0", c), 32'(req0_ready), 32'(er0));
            chk($sformatf("rr%0d.ready1", c), 32'(req1_ready), 32'(er1));
            req0_valid = (c < 12); req0_addr = 3'(k0); req0_data = 8'(8'h40 + k0);
            req1_valid = (c < 12); req1_addr = 3'(k1 + 4); req1_data = 8'(8'h80 + k1);
            if (req0_valid && er0) begin
                m_hv[0] = 1'b1; m_ha[0] = req0_addr; m_hd[0] = req0_data; k0++;
            end
            if (req1_valid && er1) begin
                m_hv[1] = 1'b1; m_ha[1] = req1_addr; m_hd[1] = req1_data; k1++;
            end
        end
        chk("rr.port0_count", 32'(w0), 32'(k0));
        chk("rr.port1_count", 32'(w1), 32'(k1));
        chk("rr.streamed", 32'(w0 + w1 >= 12), 1);
        drive_idle();

        // Clear pulse from idle.
        @(negedge clk);
        check_idle("clr.pre");
        clr_req = 1'b1;
        clear_sweep("clr");
        @(negedge clk);
        check_idle("clr.post");

        // Port-1 write granted in the cycle clr_req rises: write first, then sweep.
        req1_valid = 1'b1; req1_addr = 3'd5; req1_data = 8'h3C;
        @(negedge clk);
        check_write("clr5a.w", 3'd5, 8'h3C, 2'b10);
        drive_idle();
        clr_req = 1'b1;
        clear_sweep("clr5a");
        @(negedge clk);
        check_idle("clr5a.post");

        // Accepted in the clear-entry cycle: slot held through the sweep, drains after.
        req1_valid = 1'b1; req1_addr = 3'd5; req1_data = 8'h3C; clr_req = 1'b1;
        @(negedge clk);
        drive_idle();
        check_clear("clr5b", 0);
        for (int i = 1; i < 8; i++) begin
            @(negedge clk);
            check_clear("clr5b", i);
        end
        @(negedge clk);
        check_write("clr5b.w", 3'd5, 8'h3C, 2'b10);
        @(negedge clk);
        check_idle("clr5b.post");

        // Held clr_req: one ARB cycle between back-to-back sweeps.
        clr_req = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check_clear("lvl1", i);
        end
        @(negedge clk);
        check_idle("lvl.gap");
        clear_sweep("lvl2");
        @(negedge clk);
        check_idle("lvl.post");

        // Reset during the sweep with slot 0 full.
        req0_valid = 1'b1; req0_addr = 3'd2; req0_data = 8'h99; clr_req = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            drive_idle();
            check_clear("rst6", i);
        end
        #1 rst_n = 1'b0;
        #1 check_zero("rst6.now");
        @(negedge clk);
        check_zero("rst6.hold");
        rst_n = 1'b1;
        @(posedge clk);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check_idle($sformatf("rst6.after%0d", i));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
